// File: rtl/sfx_tone_sequencer.sv
// Multi-note square-wave sound-effect sequencer feeding Audio_Controller.
// Optional mic passthrough (mic + tone mixing) enabled by defining SFX_MIC_PASSTHRU_EN.
module sfx_tone_sequencer #(
  parameter logic [31:0] AMPLITUDE    = 32'd10000000,
  parameter int unsigned NOTE_SAMPLES = 4800,
  parameter int unsigned GAP_SAMPLES  = 480
) (
  input  logic        CLOCK_50,
  input  logic        resetn,
  input  logic        play,
  input  logic [1:0]  sfx_sel,
  output logic        busy,
  output logic        done,
  input  logic        audio_in_available,
  input  logic        audio_out_allowed,
  input  logic [31:0] left_channel_audio_in,
  input  logic [31:0] right_channel_audio_in,
  output logic        read_audio_in,
  output logic        write_audio_out,
  output logic [31:0] left_channel_audio_out,
  output logic [31:0] right_channel_audio_out
);

  localparam int unsigned MAX_SAMPLES = (NOTE_SAMPLES > GAP_SAMPLES) ? NOTE_SAMPLES : GAP_SAMPLES;
  localparam int unsigned CNT_W       = $clog2(MAX_SAMPLES + 1);
  localparam int unsigned HP_W        = 19;
  localparam logic [CNT_W-1:0] NOTE_LAST = CNT_W'(NOTE_SAMPLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_SAMPLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [1:0]        sel_q, sel_d;
  logic [1:0]        note_q, note_d;
  logic [CNT_W-1:0]  smp_q, smp_d;
  logic [HP_W-1:0]   ph_q, ph_d;
  logic              snd_q, snd_d;
  logic              done_q, done_d;

  logic              wr_c;
  logic [HP_W-1:0]   hp_c;
  logic [31:0]       tone_c;
  logic [31:0]       base_l_c;
  logic [31:0]       base_r_c;

  // Note ROM: half-periods in CLOCK_50 cycles
  function automatic logic [HP_W-1:0] half_period(input logic [1:0] sel, input logic [1:0] idx);
    logic [HP_W-1:0] hp;
    hp = 19'd23889;
    case ({sel, idx})
      4'b00_00: hp = 19'd47778;
      4'b00_01: hp = 19'd37921;
      4'b00_10: hp = 19'd31888;
      4'b00_11: hp = 19'd23889;
      4'b01_00: hp = 19'd63775;
      4'b01_01: hp = 19'd95557;
      4'b10_00: hp = 19'd23889;
      4'b11_00: hp = 19'd23889;
      4'b11_01: hp = 19'd31888;
      4'b11_10: hp = 19'd37921;
      4'b11_11: hp = 19'd47778;
      default:  hp = 19'd23889;
    endcase
    return hp;
  endfunction

  function automatic logic [1:0] last_note(input logic [1:0] sel);
    logic [1:0] n;
    case (sel)
      2'd0:    n = 2'd3;
      2'd1:    n = 2'd1;
      2'd2:    n = 2'd0;
      default: n = 2'd3;
    endcase
    return n;
  endfunction

`ifdef SFX_MIC_PASSTHRU_EN
  assign wr_c          = audio_in_available & audio_out_allowed;
  assign read_audio_in = wr_c;
  assign base_l_c      = left_channel_audio_in;
  assign base_r_c      = right_channel_audio_in;
`else
  logic unused_mic_c;
  assign unused_mic_c  = ^{audio_in_available, left_channel_audio_in, right_channel_audio_in};
  assign wr_c          = audio_out_allowed;
  assign read_audio_in = 1'b0;
  assign base_l_c      = 32'd0;
  assign base_r_c      = 32'd0;
`endif

  assign hp_c = half_period(sel_q, note_q);

  // State register
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: phases advance only on the final write of each phase
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (play) state_d = ST_PLAY;
      end
      ST_PLAY: begin
        if (wr_c && (smp_q == NOTE_LAST)) begin
          state_d = (note_q == last_note(sel_q)) ? ST_IDLE : ST_GAP;
        end
      end
      ST_GAP: begin
        if (wr_c && (smp_q == GAP_LAST)) state_d = ST_PLAY;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath next values: effect select, note index, sample and phase counters
  always_comb begin
    sel_d  = sel_q;
    note_d = note_q;
    smp_d  = smp_q;
    ph_d   = ph_q;
    snd_d  = snd_q;
    done_d = 1'b0;

    if ((state_q == ST_IDLE) && play) begin
      sel_d  = sfx_sel;
      note_d = 2'd0;
    end else if ((state_q == ST_GAP) && (state_d == ST_PLAY)) begin
      note_d = note_q + 2'd1;
    end

    if (state_d != state_q) begin
      smp_d = '0;
    end else if ((state_q != ST_IDLE) && wr_c) begin
      smp_d = smp_q + CNT_W'(1);
    end

    done_d = (state_q == ST_PLAY) && (state_d == ST_IDLE);

    // Phase generator free-runs in PLAY regardless of write cadence
    if (state_d != ST_PLAY) begin
      ph_d  = '0;
      snd_d = 1'b0;
    end else if (state_q != ST_PLAY) begin
      ph_d  = '0;
      snd_d = 1'b1;
    end else if (ph_q == (hp_c - 19'd1)) begin
      ph_d  = '0;
      snd_d = ~snd_q;
    end else begin
      ph_d  = ph_q + 19'd1;
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      sel_q  <= 2'd0;
      note_q <= 2'd0;
      smp_q  <= '0;
      ph_q   <= '0;
      snd_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      sel_q  <= sel_d;
      note_q <= note_d;
      smp_q  <= smp_d;
      ph_q   <= ph_d;
      snd_q  <= snd_d;
      done_q <= done_d;
    end
  end

  assign tone_c = (state_q != ST_PLAY) ? 32'd0 :
                  (snd_q ? AMPLITUDE : (32'd0 - AMPLITUDE));

  assign busy                    = (state_q != ST_IDLE);
  assign done                    = done_q;
  assign write_audio_out         = wr_c;
  assign left_channel_audio_out  = base_l_c + tone_c;
  assign right_channel_audio_out = base_r_c + tone_c;

endmodule

// File: doc/sfx_tone_sequencer.md
# sfx_tone_sequencer

Plays short multi-note square-wave sound effects (score jingle, miss buzz, timer beep, game-over) for the basketball game. Sits directly upstream of `Audio_Controller`: it owns the sample handshake (`read_audio_in`, `write_audio_out`) and drives `left/right_channel_audio_out`. Game logic fires one-cycle `play` pulses with an effect select; the block sequences notes and gaps, then reports `done`.

## Interface
- `AMPLITUDE`, 32'd10000000: square-wave peak; tone sample is +AMPLITUDE or -AMPLITUDE (two's complement).
- `NOTE_SAMPLES`, 4800: written samples per note (100 ms at 48 kHz).
- `GAP_SAMPLES`, 480: silent written samples between notes.

Ports (reset is asynchronous and active-low):
- `CLOCK_50` in 1: sole clock, 50 MHz.
- `resetn` in 1: asynchronous active-low reset.
- `play` in 1: one-cycle start request.
- `sfx_sel` in 2: effect select, sampled with `play`.
- `busy` out 1: high while an effect is in progress.
- `done` out 1: one-cycle pulse when an effect completes.
- `audio_in_available` in 1: from Audio_Controller.
- `audio_out_allowed` in 1: from Audio_Controller.
- `left_channel_audio_in` in 32: mic sample, left.
- `right_channel_audio_in` in 32: mic sample, right.
- `read_audio_in` out 1: consume input sample.
- `write_audio_out` out 1: push output sample.
- `left_channel_audio_out` out 32: output sample, left.
- `right_channel_audio_out` out 32: output sample, right.

## Operation
- Note ROM, half-periods in CLOCK_50 cycles (19 bits):
  - sel 0: 47778, 37921, 31888, 23889 (C5 E5 G5 C6).
  - sel 1: 63775, 95557.
  - sel 2: 23889.
  - sel 3: 23889, 31888, 37921, 47778.
- States: IDLE, PLAY, GAP.
  - IDLE: `play`=1 latches `sfx_sel`, sets note index 0, goes to PLAY.
  - PLAY: after NOTE_SAMPLES writes, goes to GAP if more notes remain. On the last note it goes to IDLE and pulses `done`.
  - GAP: after GAP_SAMPLES writes, goes to PLAY with note index + 1.
- `play` while `busy`: ignored. No retrigger and no queueing.
- Phase generator, PLAY only:
  - On note entry: half-period counter = 0, `snd` = 1.
  - Each clock the counter increments. When it equals half_period-1, `snd` toggles and the counter clears.
  - The counter is independent of the write cadence.
- Tone value: +AMPLITUDE when PLAY and `snd`=1; -AMPLITUDE when PLAY and `snd`=0; otherwise 0.
- Sample counter: increments on each `write_audio_out` cycle in PLAY/GAP and clears on every state change.
- Output arithmetic: out = base + tone, 32-bit modulo 2^32, no saturation. `base` is set by the macro (see Configuration).
- `busy` = state != IDLE.

## Timing
- Reset values: `busy`=0, `done`=0, `snd`=0, state IDLE, all counters 0. Data outputs = base + 0.
- `write_audio_out`/`read_audio_in` are combinational from the Audio_Controller flags (see Configuration). A sample transfers in any cycle where `write_audio_out`=1.
- Start latency: `play` in cycle n puts PLAY in cycle n+1. Writes from n+1 onward carry tone; a write in cycle n carries 0.
- The write in the cycle where the sample count reaches NOTE_SAMPLES-1 (or GAP_SAMPLES-1) is the last of that phase. The new state begins the next cycle.
- `done` is high for exactly the one cycle after the last note's final write, the same cycle state is IDLE again.
- No writes → the sequence stalls; the phase generator keeps running.
- `resetn` low mid-effect: immediately IDLE and tone 0. No `done` pulse.
- `play` in the same cycle as `done`: accepted, because state is already IDLE.

## Configuration
- `SFX_MIC_PASSTHRU_EN` defined:
  - base = `*_channel_audio_in`.
  - `read_audio_in` = `write_audio_out` = `audio_in_available & audio_out_allowed`.
- Not defined:
  - base = 0 and the audio_in data ports are unused.
  - `read_audio_in` = 0.
  - `write_audio_out` = `audio_out_allowed`.

## Test plan
Bench uses NOTE_SAMPLES=4, GAP_SAMPLES=2, with `audio_out_allowed` (and `audio_in_available`) high.
- Reset then idle 20 cycles → `busy`=0, `done`=0, outputs = base, no tone.
- `play` with sel 2 → 4 writes of ±10000000. `snd`=1 initially, so the first sample is +10000000. Then `done` pulses once and `busy` falls.
- `play` with sel 1 → 4 tone writes, then 2 zero-tone writes, then 4 tone writes, then `done`. Total `busy` duration is 10 cycles.
- Second `play` with sel 0 mid-effect → ignored; completion timing is unchanged.
- `resetn` low during the GAP of sel 3 → immediately `busy`=0, tone 0, no `done`.
- `SFX_MIC_PASSTHRU_EN` with left_in=32'hFFFF_FFFF and tone +10000000 → out = 32'd9999999 (wraps). `audio_in_available` low → `write_audio_out`=0 and the sequence stalls.
